// File: rtl/pwm_ramp_sequencer.sv
// Purpose: sequences a PWM instance with soft start/stop, ramping ACTIVE to a target in steps on period boundaries.
// Latency: commands take effect 1 cycle later; duty steps are registered on a period tick and show in the next period.
// Backpressure: none; one-cycle commands are acted on immediately or ignored per state, cfg is only sampled from IDLE.
`timescale 1ns/1ps

module pwm_ramp_sequencer #(
    parameter int W  = 16,
    parameter int HW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_start,
    input  logic          cmd_stop,
    input  logic [W-1:0]  cfg_period,
    input  logic [W-1:0]  cfg_target,
    input  logic [W-1:0]  cfg_step,
    input  logic [HW-1:0] cfg_hold,
    output logic [W-1:0]  PERIOD,
    output logic [W-1:0]  ACTIVE,
    output logic          start,
    output logic          stop,
    output logic          busy,
    output logic          at_target,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_HOLD      = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_t;

    localparam logic [W-1:0]  ONE_W = {{(W-1){1'b0}}, 1'b1};
    localparam logic [HW-1:0] ONE_H = {{(HW-1){1'b0}}, 1'b1};

    state_t        state_q,  state_d;
    logic [W-1:0]  pcnt_q,   pcnt_d;
    logic [HW-1:0] hcnt_q,   hcnt_d;
    logic [W-1:0]  period_q, period_d;
    logic [W-1:0]  target_q, target_d;
    logic [W-1:0]  step_q,   step_d;
    logic [HW-1:0] hold_q,   hold_d;
    logic [W-1:0]  active_q, active_d;
    logic          err_q,    err_d;
    logic          stop_q,   stop_d;

    logic          running;
    logic          tick;
    logic [HW-1:0] hold_eff;
    logic [HW-1:0] hcnt_inc;
    logic          step_fire;
    logic [W:0]    up_sum;
    logic          up_hit;
    logic [W-1:0]  dn_val;
    logic [W-1:0]  cfg_eff_target;
    logic          start_req;

    // Derived timing and arithmetic terms shared by the next-state logic.
    always_comb begin
        running        = (state_q != S_IDLE);
        tick           = running && (pcnt_q == (period_q - ONE_W));
        hold_eff       = (hold_q == '0) ? ONE_H : hold_q;
        hcnt_inc       = hcnt_q + ONE_H;
        step_fire      = tick && (hcnt_inc == hold_eff);
        // Sum kept one bit wider so a large step never wraps past the target.
        up_sum         = {1'b0, active_q} + {1'b0, step_q};
        up_hit         = (up_sum >= {1'b0, target_q});
        dn_val         = (active_q > step_q) ? (active_q - step_q) : '0;
        cfg_eff_target = (cfg_target < cfg_period) ? cfg_target : cfg_period;
        // A simultaneous stop always overrides start.
        start_req      = cmd_start && !cmd_stop;
    end

    // Next-state: FSM transitions, duty stepping, period/hold counters and config latching.
    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        hcnt_d   = hcnt_q;
        period_d = period_q;
        target_d = target_q;
        step_d   = step_q;
        hold_d   = hold_q;
        active_d = active_q;
        err_d    = err_q;
        stop_d   = 1'b0;

        if (running) begin
            pcnt_d = tick ? '0 : (pcnt_q + ONE_W);
            if (tick) begin
                hcnt_d = step_fire ? '0 : hcnt_inc;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    if ((cfg_period == '0) || (cfg_step == '0)) begin
                        err_d = 1'b1;
                    end else begin
                        period_d = cfg_period;
                        target_d = cfg_eff_target;
                        step_d   = cfg_step;
                        hold_d   = cfg_hold;
                        err_d    = 1'b0;
                        active_d = '0;
                        pcnt_d   = '0;
                        hcnt_d   = '0;
                        state_d  = S_RAMP_UP;
                    end
                end
            end
            S_RAMP_UP: begin
                if (cmd_stop) begin
                    state_d = S_RAMP_DOWN;
                    hcnt_d  = '0;
                end else if (step_fire) begin
                    if (up_hit) begin
                        active_d = target_q;
                        state_d  = S_HOLD;
                    end else begin
                        active_d = up_sum[W-1:0];
                    end
                end
            end
            S_HOLD: begin
                // Hold counting is meaningless at target; keep it parked at zero.
                hcnt_d = '0;
                if (cmd_stop) begin
                    state_d = S_RAMP_DOWN;
                end
            end
            S_RAMP_DOWN: begin
                if (start_req) begin
                    state_d = S_RAMP_UP;
                    hcnt_d  = '0;
                end else if (step_fire) begin
                    if (active_q == '0) begin
                        state_d = S_IDLE;
                        stop_d  = 1'b1;
                        pcnt_d  = '0;
                        hcnt_d  = '0;
                    end else begin
                        active_d = dn_val;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pcnt_q   <= '0;
            hcnt_q   <= '0;
            period_q <= '0;
            target_q <= '0;
            step_q   <= '0;
            hold_q   <= '0;
            active_q <= '0;
            err_q    <= 1'b0;
            stop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            hcnt_q   <= hcnt_d;
            period_q <= period_d;
            target_q <= target_d;
            step_q   <= step_d;
            hold_q   <= hold_d;
            active_q <= active_d;
            err_q    <= err_d;
            stop_q   <= stop_d;
        end
    end

    assign PERIOD    = period_q;
    assign ACTIVE    = active_q;
    assign start     = running;
    assign busy      = running;
    assign at_target = (state_q == S_HOLD);
    assign stop      = stop_q;
    assign err       = err_q;

endmodule

// File: doc/pwm_ramp_sequencer.md
# pwm_ramp_sequencer

Controller that sequences the `PWM` block: latches a period/duty configuration, drives the PWM's `PERIOD`, `ACTIVE`, `start` and `stop` inputs, and ramps `ACTIVE` up to a target and back down in programmable steps. Duty changes occur only on PWM period boundaries. It sits between the register/command interface and the PWM instance, and gives the PWM a soft start and a soft stop.

## Interface

Parameters:
- `W`, 16: width of period/duty values.
- `HW`, 8: width of hold count.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low; asserts `reset`=0 to clear all state.
- `cmd_start` input 1: one-cycle request to start or resume ramp-up.
- `cmd_stop` input 1: one-cycle request to ramp down and stop.
- `cfg_period` input W: PWM period in clocks; sampled on an accepted `cmd_start` from IDLE.
- `cfg_target` input W: final duty in clocks; sampled with `cfg_period`.
- `cfg_step` input W: duty increment/decrement per step; sampled with `cfg_period`.
- `cfg_hold` input HW: number of period boundaries per step; 0 is treated as 1.
- `PERIOD` output W: to PWM.
- `ACTIVE` output W: to PWM.
- `start` output 1: to PWM; high while running.
- `stop` output 1: to PWM; one-cycle pulse at the end of the ramp-down.
- `busy` output 1: high in any state other than IDLE.
- `at_target` output 1: high in HOLD.
- `err` output 1: sticky config error; cleared by the next accepted valid start.

## Operation

- States are IDLE, RAMP_UP, HOLD and RAMP_DOWN.
- Period counter `pcnt` counts 0..PERIOD-1 while `start`=1. `tick` is asserted when `pcnt`==PERIOD-1. `pcnt` wraps to 0 on `tick`.
- Hold counter `hcnt` counts ticks. A step fires on the tick where `hcnt` reaches max(`cfg_hold`,1); `hcnt` then clears.
- Effective target is min(`cfg_target`, `cfg_period`), latched at start.
- IDLE + `cmd_start`:
  - If `cfg_period`==0 or `cfg_step`==0: set `err`=1 and remain in IDLE.
  - Otherwise: latch the config, clear `err`, set `ACTIVE`=0, clear `pcnt` and `hcnt`, and go to RAMP_UP.
- RAMP_UP, on each step: `ACTIVE` = min(`ACTIVE`+`cfg_step`, target). The sum is computed at W+1 bits with no wrap. When the new value equals target, go to HOLD.
- Target of 0: RAMP_UP goes to HOLD on the first step with `ACTIVE` held at 0.
- HOLD: `ACTIVE` is constant. `cmd_stop` moves the FSM to RAMP_DOWN.
- RAMP_DOWN, on each step: `ACTIVE` = max(`ACTIVE`-`cfg_step`, 0), saturating. On the step where `ACTIVE` is already 0, go to IDLE.
- Leaving RAMP_DOWN for IDLE: `start`=0, `stop`=1 for that one cycle, and `PERIOD` holds its last value.
- `cmd_stop` in RAMP_UP: go to RAMP_DOWN from the current `ACTIVE`; `hcnt` is cleared.
- `cmd_start` in RAMP_DOWN: go to RAMP_UP from the current `ACTIVE`; `hcnt` is cleared and the config is not re-sampled.
- `cmd_start` in RAMP_UP or HOLD: ignored.
- `cmd_stop` in IDLE: ignored, no `stop` pulse.
- `cmd_start` and `cmd_stop` in the same cycle: `cmd_stop` wins.
- `cfg_*` changes while busy have no effect.

## Timing

- Reset values: `PERIOD`=0, `ACTIVE`=0, `start`=0, `stop`=0, `busy`=0, `at_target`=0, `err`=0, state IDLE, and all counters 0.
- An accepted `cmd_start` in cycle N gives, in cycle N+1: `busy`=1, `start`=1, `PERIOD`=`cfg_period`, `ACTIVE`=0, `pcnt`=0.
- Ticks fall in cycles N+PERIOD, N+2·PERIOD, and so on.
- An `ACTIVE` update is registered on a step tick and is visible in the following cycle. That cycle is the first cycle of the new PWM period.
- A state change caused by a step becomes visible in the same cycle as the new `ACTIVE`.
- `cmd_stop`/`cmd_start` state changes are visible 1 cycle after the command; `ACTIVE` is unchanged at that point.
- The `err` set is visible 1 cycle after the rejected `cmd_start`.
- `stop` is asserted in the cycle in which `busy` falls and is deasserted one cycle later.
- Reset asserted mid-operation forces all outputs to their reset values immediately, without waiting for a clock edge. After reset is released, a new `cmd_start` is required.

## Test plan

- Basic ramp. Stimulus: `cfg_period`=10, `cfg_target`=4, `cfg_step`=1, `cfg_hold`=1, then `cmd_start`. Required: `ACTIVE` steps 0→1→2→3→4 every 10 cycles, and `at_target`=1 after the 4th tick.
- Ramp-down and stop. Stimulus: from HOLD above, `cmd_stop`. Required: `ACTIVE` steps 4→3→2→1→0 every 10 cycles; one tick after reaching 0, `stop` pulses for 1 cycle and `start`=`busy`=0.
- Saturation and clamping. Stimulus: `cfg_period`=10, `cfg_target`=25, `cfg_step`=3, `cfg_hold`=2. Required: `ACTIVE` takes 0→3→6→9→10, with a step every 20 cycles and a final value of 10. On ramp-down, `ACTIVE` takes 10→7→4→1→0 with no underflow.
- Error path. Stimulus: `cmd_start` with `cfg_period`=0. Required: `err`=1, `busy`=0, no `start`. A following valid `cmd_start` clears `err` and begins RAMP_UP.
- Reversal and priority:
  - `cmd_stop` at `ACTIVE`=2 during RAMP_UP must go to RAMP_DOWN from 2.
  - `cmd_start` during RAMP_DOWN at `ACTIVE`=1 must go to RAMP_UP from 1.
  - Simultaneous `cmd_start`+`cmd_stop` in HOLD must go to RAMP_DOWN.
- Async reset. Stimulus: assert `reset`=0 mid-RAMP_UP, between clock edges. Required: all outputs are 0 before the next edge. After release, the block idles until `cmd_start`.
